// File: rtl/xcpt_trap_sequencer.sv
// Trap-entry / mret sequencer: flush, then mepc/mcause/mtval CSR writes, then a fetch redirect.
// Accept to redirect takes 5 cycles when unstalled; csr_wack and redirect_ready stall their states, req_ready is low while busy.
module xcpt_trap_sequencer #(
   parameter int XLEN     = 64,
   parameter int VEC_BITS = 6
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            xcpt_valid,
   input  logic [XLEN-1:0] xcpt_cause,
   input  logic [XLEN-1:0] xcpt_pc,
   input  logic [XLEN-1:0] xcpt_tval,
   input  logic            mret_valid,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   output logic            req_ready,
   output logic            flush,
   output logic            csr_we,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wdata,
   input  logic            csr_wack,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            redirect_ready,
   output logic            busy
);

   typedef enum logic [2:0] {
      IDLE, FLUSH, WR_EPC, WR_CAUSE, WR_TVAL, REDIRECT
   } state_t;

   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;
   localparam logic [11:0] CSR_MTVAL  = 12'h343;

   state_t            r_state;
   logic [XLEN-1:0]   r_cause;
   logic [XLEN-1:1]   r_pc;
   logic [XLEN-1:0]   r_tval;
   logic [XLEN-1:0]   r_mtvec;
   logic [XLEN-1:1]   r_mepc;
   logic              r_is_mret;

   logic              r_req_ready;
   logic              r_flush;
   logic              r_csr_we;
   logic [11:0]       r_csr_addr;
   logic [XLEN-1:0]   r_csr_wdata;
   logic              r_redirect_valid;
   logic [XLEN-1:0]   r_redirect_pc;
   logic              r_busy;

   logic              w_is_irq;
   logic [XLEN-1:0]   w_base;
   logic [XLEN-1:0]   w_vec_off;
   logic [XLEN-1:0]   w_xcpt_target;
   logic [XLEN-1:0]   w_mret_target;
   logic [XLEN-1:0]   w_epc;
   logic [XLEN-1:0]   w_tval;
   logic              w_unused;

   // PC bit 0 is always cleared in mepc and redirect targets, so it is never stored.
   assign w_unused      = ^{xcpt_pc[0], mepc[0]};

   assign w_is_irq      = r_cause[XLEN-1];
   assign w_base        = {r_mtvec[XLEN-1:2], 2'b00};
   assign w_vec_off     = {{(XLEN-VEC_BITS-2){1'b0}}, r_cause[VEC_BITS-1:0], 2'b00};
   assign w_xcpt_target = (r_mtvec[1:0] == 2'b01 && w_is_irq) ? (w_base + w_vec_off) : w_base;
   assign w_mret_target = {r_mepc, 1'b0};
   assign w_epc         = {r_pc, 1'b0};
   assign w_tval        = w_is_irq ? '0 : r_tval;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state          <= IDLE;
         r_cause          <= '0;
         r_pc             <= '0;
         r_tval           <= '0;
         r_mtvec          <= '0;
         r_mepc           <= '0;
         r_is_mret        <= 1'b0;
         r_req_ready      <= 1'b1;
         r_flush          <= 1'b0;
         r_csr_we         <= 1'b0;
         r_csr_addr       <= '0;
         r_csr_wdata      <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_busy           <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (xcpt_valid || mret_valid) begin
                  r_cause     <= xcpt_cause;
                  r_pc        <= xcpt_pc[XLEN-1:1];
                  r_tval      <= xcpt_tval;
                  r_mtvec     <= mtvec;
                  r_mepc      <= mepc[XLEN-1:1];
                  r_is_mret   <= !xcpt_valid;
                  r_state     <= FLUSH;
                  r_flush     <= 1'b1;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
               end
            end
            FLUSH: begin
               r_flush <= 1'b0;
               if (r_is_mret) begin
                  r_state          <= REDIRECT;
                  r_redirect_valid <= 1'b1;
                  r_redirect_pc    <= w_mret_target;
               end else begin
                  r_state     <= WR_EPC;
                  r_csr_we    <= 1'b1;
                  r_csr_addr  <= CSR_MEPC;
                  r_csr_wdata <= w_epc;
               end
            end
            WR_EPC: begin
               if (csr_wack) begin
                  r_state     <= WR_CAUSE;
                  r_csr_addr  <= CSR_MCAUSE;
                  r_csr_wdata <= r_cause;
               end
            end
            WR_CAUSE: begin
               if (csr_wack) begin
                  r_state     <= WR_TVAL;
                  r_csr_addr  <= CSR_MTVAL;
                  r_csr_wdata <= w_tval;
               end
            end
            WR_TVAL: begin
               if (csr_wack) begin
                  r_state          <= REDIRECT;
                  r_csr_we         <= 1'b0;
                  r_csr_addr       <= '0;
                  r_csr_wdata      <= '0;
                  r_redirect_valid <= 1'b1;
                  r_redirect_pc    <= w_xcpt_target;
               end
            end
            REDIRECT: begin
               if (redirect_ready) begin
                  r_state          <= IDLE;
                  r_redirect_valid <= 1'b0;
                  r_redirect_pc    <= '0;
                  r_busy           <= 1'b0;
                  r_req_ready      <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign req_ready      = r_req_ready;
   assign flush          = r_flush;
   assign csr_we         = r_csr_we;
   assign csr_addr       = r_csr_addr;
   assign csr_wdata      = r_csr_wdata;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign busy           = r_busy;

endmodule

// File: tb/tb_xcpt_trap_sequencer.sv
// Directed bench for xcpt_trap_sequencer: per-cycle output vectors compared against hand-built expectations.
module tb_xcpt_trap_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        xcpt_valid = 1'b0;
   logic [63:0] xcpt_cause = '0;
   logic [63:0] xcpt_pc = '0;
   logic [63:0] xcpt_tval = '0;
   logic        mret_valid = 1'b0;
   logic [63:0] mtvec = '0;
   logic [63:0] mepc = '0;
   logic        req_ready;
   logic        flush;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [63:0] csr_wdata;
   logic        csr_wack = 1'b1;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        redirect_ready = 1'b1;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   xcpt_trap_sequencer #(.XLEN(64), .VEC_BITS(6)) dut (
      .CLK(CLK), .RST(RST),
      .xcpt_valid(xcpt_valid), .xcpt_cause(xcpt_cause), .xcpt_pc(xcpt_pc), .xcpt_tval(xcpt_tval),
      .mret_valid(mret_valid), .mtvec(mtvec), .mepc(mepc),
      .req_ready(req_ready), .flush(flush),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wack(csr_wack),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   // {flush, csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, busy, req_ready}
   logic [144:0] w_obs;
   assign w_obs = {flush, csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, busy, req_ready};

   function automatic logic [144:0] mk(input logic f, input logic we, input logic [11:0] a,
                                       input logic [63:0] d, input logic rv, input logic [63:0] rp,
                                       input logic b, input logic r);
      return {f, we, a, d, rv, rp, b, r};
   endfunction

   task automatic test_reset();
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      n_total++;
      if (w_obs !== mk(0, 0, 12'h0, 64'h0, 0, 64'h0, 0, 1))
         $display("FAIL reset_hold got %h exp %h", w_obs, mk(0, 0, 12'h0, 64'h0, 0, 64'h0, 0, 1));
      else n_pass++;
      @(posedge CLK); #1;
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         n_total++;
         if (w_obs !== mk(0, 0, 12'h0, 64'h0, 0, 64'h0, 0, 1))
            $display("FAIL reset_idle[%0d] got %h exp %h", i, w_obs, mk(0, 0, 12'h0, 64'h0, 0, 64'h0, 0, 1));
         else n_pass++;
      end
   endtask

   task automatic test_direct();
      logic [144:0] exp_a [7];
      exp_a[0] = mk(0, 0, 12'h000, 64'h0,          0, 64'h0,          0, 1);
      exp_a[1] = mk(1, 0, 12'h000, 64'h0,          0, 64'h0,          1, 0);
      exp_a[2] = mk(0, 1, 12'h341, 64'h8000_0104,  0, 64'h0,          1, 0);
      exp_a[3] = mk(0, 1, 12'h342, 64'h2,          0, 64'h0,          1, 0);
      exp_a[4] = mk(0, 1, 12'h343, 64'h13,         0, 64'h0,          1, 0);
      exp_a[5] = mk(0, 0, 12'h000, 64'h0,          1, 64'h8000_0000,  1, 0);
      exp_a[6] = mk(0, 0, 12'h000, 64'h0,          0, 64'h0,          0, 1);
      @(posedge CLK); #1;
      xcpt_cause = 64'h2; xcpt_pc = 64'h8000_0104; xcpt_tval = 64'h13; mtvec = 64'h8000_0000;
      xcpt_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge CLK);
         n_total++;
         if (w_obs !== exp_a[i]) $display("FAIL direct[%0d] got %h exp %h", i, w_obs, exp_a[i]);
         else n_pass++;
         @(posedge CLK); #1;
         xcpt_valid = 1'b0;
      end
   endtask

   task automatic test_vectored();
      logic [144:0] exp_a [7];
      exp_a[0] = mk(0, 0, 12'h000, 64'h0,                   0, 64'h0,          0, 1);
      exp_a[1] = mk(1, 0, 12'h000, 64'h0,                   0, 64'h0,          1, 0);
      exp_a[2] = mk(0, 1, 12'h341, 64'h8000_0200,           0, 64'h0,          1, 0);
      exp_a[3] = mk(0, 1, 12'h342, 64'h8000_0000_0000_0007, 0, 64'h0,          1, 0);
      exp_a[4] = mk(0, 1, 12'h343, 64'h0,                   0, 64'h0,          1, 0);
      exp_a[5] = mk(0, 0, 12'h000, 64'h0,                   1, 64'h8000_001C,  1, 0);
      exp_a[6] = mk(0, 0, 12'h000, 64'h0,                   0, 64'h0,          0, 1);
      @(posedge CLK); #1;
      xcpt_cause = 64'h8000_0000_0000_0007; xcpt_pc = 64'h8000_0200; xcpt_tval = 64'hFF;
      mtvec = 64'h8000_0001;
      xcpt_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge CLK);
         n_total++;
         if (w_obs !== exp_a[i]) $display("FAIL vectored[%0d] got %h exp %h", i, w_obs, exp_a[i]);
         else n_pass++;
         @(posedge CLK); #1;
         xcpt_valid = 1'b0;
      end
   endtask

   // Mode 2'b10 must behave as direct; odd PC must be written to mepc with bit 0 cleared.
   task automatic test_backpressure();
      logic [144:0] exp_a [12];
      logic         wack_a [12];
      logic         rdy_a [12];
      wack_a = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
      rdy_a  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
      exp_a[0] = mk(0, 0, 12'h000, 64'h0, 0, 64'h0, 0, 1);
      exp_a[1] = mk(1, 0, 12'h000, 64'h0, 0, 64'h0, 1, 0);
      exp_a[2] = mk(0, 1, 12'h341, 64'h8000_0300, 0, 64'h0, 1, 0);
      for (int k = 3; k <= 6; k++) exp_a[k] = mk(0, 1, 12'h342, 64'h5, 0, 64'h0, 1, 0);
      exp_a[7] = mk(0, 1, 12'h343, 64'h1234, 0, 64'h0, 1, 0);
      for (int k = 8; k <= 10; k++) exp_a[k] = mk(0, 0, 12'h000, 64'h0, 1, 64'h8000_0100, 1, 0);
      exp_a[11] = mk(0, 0, 12'h000, 64'h0, 0, 64'h0, 0, 1);
      @(posedge CLK); #1;
      xcpt_cause = 64'h5; xcpt_pc = 64'h8000_0301; xcpt_tval = 64'h1234; mtvec = 64'h8000_0102;
      xcpt_valid = 1'b1;
      csr_wack = wack_a[0]; redirect_ready = rdy_a[0];
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         n_total++;
         if (w_obs !== exp_a[i]) $display("FAIL backpressure[%0d] got %h exp %h", i, w_obs, exp_a[i]);
         else n_pass++;
         @(posedge CLK); #1;
         xcpt_valid = 1'b0;
         if (i == 0) begin
            xcpt_cause = 64'h8000_0000_0000_003F; xcpt_pc = 64'hDEAD_BEEF;
            xcpt_tval = 64'hCAFE; mtvec = 64'h1111_1101; mepc = 64'h2222_2222;
         end
         if (i == 3) mret_valid = 1'b1;
         if (i == 5) mret_valid = 1'b0;
         if (i < 11) begin
            csr_wack = wack_a[i+1]; redirect_ready = rdy_a[i+1];
         end
      end
      csr_wack = 1'b1; redirect_ready = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [144:0] exp_a [10];
      exp_a[0] = mk(0, 0, 12'h000, 64'h0,         0, 64'h0,         0, 1);
      exp_a[1] = mk(1, 0, 12'h000, 64'h0,         0, 64'h0,         1, 0);
      exp_a[2] = mk(0, 1, 12'h341, 64'h8000_0400, 0, 64'h0,         1, 0);
      exp_a[3] = mk(0, 1, 12'h342, 64'h3,         0, 64'h0,         1, 0);
      exp_a[4] = mk(0, 1, 12'h343, 64'h77,        0, 64'h0,         1, 0);
      exp_a[5] = mk(0, 0, 12'h000, 64'h0,         1, 64'h8000_0000, 1, 0);
      exp_a[6] = mk(0, 0, 12'h000, 64'h0,         0, 64'h0,         0, 1);
      exp_a[7] = mk(1, 0, 12'h000, 64'h0,         0, 64'h0,         1, 0);
      exp_a[8] = mk(0, 0, 12'h000, 64'h0,         1, 64'h8000_0202, 1, 0);
      exp_a[9] = mk(0, 0, 12'h000, 64'h0,         0, 64'h0,         0, 1);
      @(posedge CLK); #1;
      xcpt_cause = 64'h3; xcpt_pc = 64'h8000_0400; xcpt_tval = 64'h77; mtvec = 64'h8000_0000;
      mepc = 64'h8000_0203;
      xcpt_valid = 1'b1; mret_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         n_total++;
         if (w_obs !== exp_a[i]) $display("FAIL simultaneous[%0d] got %h exp %h", i, w_obs, exp_a[i]);
         else n_pass++;
         @(posedge CLK); #1;
         xcpt_valid = 1'b0;
         if (i == 6) mret_valid = 1'b0;
      end
   endtask

   task automatic test_reset_midop();
      logic [144:0] exp_a [10];
      logic         wack_a [10];
      logic         rst_a [10];
      wack_a = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
      rst_a  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      exp_a[0] = mk(0, 0, 12'h000, 64'h0,         0, 64'h0, 0, 1);
      exp_a[1] = mk(1, 0, 12'h000, 64'h0,         0, 64'h0, 1, 0);
      exp_a[2] = mk(0, 1, 12'h341, 64'h8000_0500, 0, 64'h0, 1, 0);
      exp_a[3] = mk(0, 1, 12'h342, 64'h1,         0, 64'h0, 1, 0);
      exp_a[4] = mk(0, 1, 12'h342, 64'h1,         0, 64'h0, 1, 0);
      for (int k = 5; k < 10; k++) exp_a[k] = mk(0, 0, 12'h000, 64'h0, 0, 64'h0, 0, 1);
      @(posedge CLK); #1;
      xcpt_cause = 64'h1; xcpt_pc = 64'h8000_0500; xcpt_tval = 64'hAB; mtvec = 64'h8000_0000;
      xcpt_valid = 1'b1;
      csr_wack = wack_a[0]; RST = rst_a[0];
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         n_total++;
         if (w_obs !== exp_a[i]) $display("FAIL reset_midop[%0d] got %h exp %h", i, w_obs, exp_a[i]);
         else n_pass++;
         @(posedge CLK); #1;
         xcpt_valid = 1'b0;
         if (i < 9) begin
            csr_wack = wack_a[i+1]; RST = rst_a[i+1];
         end
      end
      csr_wack = 1'b1; RST = 1'b0;
   endtask

   initial begin
      test_reset();
      test_direct();
      test_vectored();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/xcpt_trap_sequencer.md
# xcpt_trap_sequencer

Trap-entry and trap-return sequencer at the commit end of the Lagarto exception path. It accepts the single prioritized exception (valid flag plus 64-bit cause) together with the faulting PC and trap value. It then runs a fixed multi-cycle sequence: pipeline flush, machine-CSR writes (mepc, mcause, mtval) over a handshaked CSR write port, and a PC redirect to the trap vector. It also services mret by redirecting to mepc.

## Interface
- XLEN, 64, datapath width for cause, PC, tval, CSR data.
- VEC_BITS, 6, number of low cause bits used for the vectored-interrupt offset.

Ports:
- CLK  in  1  core clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- xcpt_valid  in  1  prioritized exception pending; held with payload until accepted.
- xcpt_cause  in  XLEN  cause; bit XLEN-1 = interrupt.
- xcpt_pc  in  XLEN  PC of trapping instruction.
- xcpt_tval  in  XLEN  trap value (bad address / instruction bits).
- mret_valid  in  1  mret committed; held until accepted.
- mtvec  in  XLEN  current mtvec CSR value.
- mepc  in  XLEN  current mepc CSR value.
- req_ready  out  1  request accepted this cycle if a valid is high; equals (state==IDLE).
- flush  out  1  one-cycle pipeline flush pulse.
- csr_we  out  1  CSR write request.
- csr_addr  out  12  CSR address.
- csr_wdata  out  XLEN  CSR write data.
- csr_wack  in  1  CSR write accepted; may be asserted in the same cycle as csr_we.
- redirect_valid  out  1  fetch redirect request.
- redirect_pc  out  XLEN  redirect target.
- redirect_ready  in  1  frontend accepts the redirect.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, FLUSH, WR_EPC, WR_CAUSE, WR_TVAL, REDIRECT.
- Accept: in IDLE, xcpt_valid or mret_valid.
  - Latch cause, pc, tval, mtvec and mepc, plus an is_mret flag.
  - xcpt_valid wins when both valids are high. mret stays pending because req_ready falls, so it is re-presented later.
- Exception path: IDLE → FLUSH → WR_EPC → WR_CAUSE → WR_TVAL → REDIRECT → IDLE.
- mret path: IDLE → FLUSH → REDIRECT → IDLE. No CSR writes.
- FLUSH: flush=1 for exactly one cycle, then advance unconditionally.
- CSR write states: csr_we=1, with addr and data held stable until csr_wack; advance on csr_we&csr_wack.
  - WR_EPC: addr 0x341, data = {pc[XLEN-1:1],1'b0}.
  - WR_CAUSE: addr 0x342, data = cause.
  - WR_TVAL: addr 0x343, data = tval, or 0 when cause[XLEN-1]=1 (interrupt).
- Redirect target:
  - mret: {mepc[XLEN-1:1],1'b0}.
  - Exception: base = {mtvec[XLEN-1:2],2'b00}.
    - If mtvec[1:0]==2'b01 and interrupt: target = base + (cause[VEC_BITS-1:0] << 2).
    - Otherwise target = base. Modes 2'b10 and 2'b11 are treated as direct.
  - Addition is modulo 2^XLEN, no carry out.
- REDIRECT: redirect_valid=1 with redirect_pc stable; leave on redirect_ready. req_ready is 0 in that cycle, so a new request is taken one cycle after return to IDLE.
- Inputs are ignored outside IDLE. Latched payload is immune to input changes after accept.

## Timing
- Reset (RST=1 at an edge): state=IDLE and all latches cleared. After reset:
  - flush, csr_we, redirect_valid, busy = 0.
  - csr_addr = 0, csr_wdata = 0, redirect_pc = 0.
  - req_ready = 1.
- RST mid-sequence aborts immediately. No further CSR writes or redirect; partial CSR writes are not rolled back.
- Accept at edge N: flush high in cycle N+1, csr_we high from N+2.
- With csr_wack tied high, the exception path takes:
  - WR_EPC at N+2, WR_CAUSE at N+3, WR_TVAL at N+4.
  - redirect_valid from N+5; IDLE at N+6 if redirect_ready is high at N+5.
- With redirect_ready tied high, mret asserts redirect_valid at N+2 and returns to IDLE at N+3.
- Each cycle csr_wack is low extends the current write state by one cycle. Each cycle redirect_ready is low extends REDIRECT by one cycle.
- csr_wack or redirect_ready asserted outside their states has no effect.

## Test plan
- Reset: hold RST 2 cycles, then release. Expect all outputs 0, req_ready=1 and busy=0 until the first valid.
- Exception, direct mode: cause=0x2, pc=0x8000_0104, tval=0x0000_0013, mtvec=0x8000_0000, wack and ready tied high.
  - Expect flush at N+1.
  - Expect writes (0x341,0x8000_0104), (0x342,0x2), (0x343,0x13) at N+2..N+4.
  - Expect redirect_pc=0x8000_0000 at N+5.
- Vectored interrupt: cause=0x8000_0000_0000_0007, mtvec=0x8000_0001, tval=0xFF.
  - Expect mtval write data 0.
  - Expect redirect_pc=0x8000_001C.
- Backpressure: csr_wack low 3 cycles in WR_CAUSE, then redirect_ready low 2 cycles.
  - Expect addr 0x342 and its data held stable for 4 cycles, and redirect_pc held stable.
  - Expect a total sequence length of 5 extra cycles, and no input sampled during the sequence.
- Simultaneous requests: xcpt_valid and mret_valid high together with mepc=0x8000_0203.
  - Expect the exception sequence first.
  - Then the mret is accepted one cycle after IDLE, with flush followed by redirect_pc=0x8000_0202 and no csr_we.
- Reset mid-op: assert RST during WR_CAUSE with csr_wack low. Expect csr_we=0 and state IDLE at the next edge, no WR_TVAL write and no redirect.
